imem_fetch_ctrl: RTL

//  Sequences a byte-wide, synchronous-read instruction memory (2^ADDR_W bytes).

---
 rtl/imem_fetch_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Fetch sequencer for a byte-wide, synchronous-read instruction memory.
// A 32-bit big-endian instruction is assembled from four consecutive byte
// reads. The same memory port serves a byte-serial program-load path, which
// has priority while the controller is idle.

module imem_fetch_ctrl #(
  parameter int                   PC_SIZE   = 32,
  parameter int                   INST_SIZE = 32,
  parameter int                   MEM_WIDTH = 8,
  parameter int                   ADDR_W    = 18,
  parameter logic [INST_SIZE-1:0] ERR_INST  = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic [PC_SIZE-1:0]   fetch_pc,
  output logic                 fetch_ready,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [INST_SIZE-1:0] inst,
  output logic                 inst_err,
  input  logic                 load_valid,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [MEM_WIDTH-1:0] load_data,
  output logic                 load_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [MEM_WIDTH-1:0] mem_wdata,
  input  logic [MEM_WIDTH-1:0] mem_rdata,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [1:0]           r_idx;
  logic [INST_SIZE-1:0] r_inst;
  logic                 r_inst_err;
  logic                 r_inst_valid;

  logic                 w_accept;
  logic                 w_fetch_err;
  logic [INST_SIZE-1:0] w_inst_shift;

  // A fetch is illegal when it is not word aligned or lies above the array.
  assign w_accept     = fetch_req & fetch_ready;
  assign w_fetch_err  = (fetch_pc[1:0] != 2'b00) ||
                        (fetch_pc[PC_SIZE-1:ADDR_W] != '0);
  // Bytes arrive most-significant first, so each new byte enters at the bottom.
  assign w_inst_shift = {r_inst[INST_SIZE-MEM_WIDTH-1:0], mem_rdata};

  // Fetch sequencing: accept, issue four byte reads, drain the last one,
  // then hold the result until the consumer takes it.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_idx        <= '0;
      r_inst       <= '0;
      r_inst_err   <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc  <= fetch_pc[ADDR_W-1:0];
            r_idx <= '0;
            if (w_fetch_err) begin
              r_inst     <= ERR_INST;
              r_inst_err <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_inst_err <= 1'b0;
              r_state    <= S_READ;
            end
          end
        end
        S_READ: begin
          r_idx <= r_idx + 2'd1;
          // Read data lags the address by one cycle, so the first READ
          // cycle has nothing to capture yet.
          if (r_idx != 2'd0) r_inst <= w_inst_shift;
          if (r_idx == 2'd3) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_inst  <= w_inst_shift;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!r_inst_valid) begin
            r_inst_valid <= 1'b1;
          end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory port and handshake steering; loads own the port only while idle.
  // Everything is forced quiet while reset is held so no stray write occurs.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          load_ready  = 1'b1;
          fetch_ready = ~load_valid;
          mem_we      = load_valid;
          mem_addr    = load_addr;
          mem_wdata   = load_data;
        end
        S_READ: begin
          // An aligned pc plus 0..3 never carries out of the word.
          mem_addr = r_pc + {{(ADDR_W-2){1'b0}}, r_idx};
        end
        default: ;
      endcase
    end
  end

  assign inst       = r_inst;
  assign inst_err   = r_inst_err;
  assign inst_valid = r_inst_valid;
  assign busy       = (r_state != S_IDLE);

endmodule
